// File: rtl/xlr8_xb_fifo_bridge.sv
// xlr8_xb_fifo_bridge
//   Bridges the AVR data-memory register bus to a user XB through two byte
//   FIFOs: TX (AVR -> XB) and RX (XB -> AVR). Also provides a control
//   register, a status register with sticky error flags and a maskable,
//   level-sensitive interrupt.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   clken            qualifies every state update
//   dbus_in          AVR write data
//   dbus_out         AVR read data (combinational, 0x00 when not read)
//   io_out_en        high while one of the four registers is read
//   ramadr, ramre,
//   ramwe, dm_sel    DM address / read enable / write enable / select
//   tx_data/valid    TX stream to XB, tx_ready from XB
//   rx_data/valid    RX stream from XB, rx_ready to XB
//   xb_enable        CTRL.EN
//   irq              interrupt request
//
// CTRL   : [0] EN [1] RXIE [2] TXIE [3] ERRIE [6:4] spare [7] FLUSH (wo)
// STATUS : [0] TX_EMPTY [1] TX_FULL [2] RX_EMPTY [3] RX_FULL
//          [4] TX_OVF (w1c) [5] RX_UDF (w1c) [6] irq [7] 0
module xlr8_xb_fifo_bridge #(
  parameter logic [7:0] CTRL_ADDR   = 8'h00,
  parameter logic [7:0] STATUS_ADDR = 8'h00,
  parameter logic [7:0] TXD_ADDR    = 8'h00,
  parameter logic [7:0] RXD_ADDR    = 8'h00,
  parameter int         DEPTH       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       xb_enable,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [6:0]    r_ctrl;
  logic          r_tx_ovf;
  logic          r_rx_udf;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;

  logic w_ctrl_re, w_ctrl_we, w_stat_re, w_stat_we;
  logic w_txd_re, w_txd_we, w_rxd_re;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_flush, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_ovf_set, w_udf_set;
  logic [7:0] w_status;
  logic [7:0] w_rd;

  assign w_ctrl_re = dm_sel && (ramadr == CTRL_ADDR)   && ramre;
  assign w_ctrl_we = dm_sel && (ramadr == CTRL_ADDR)   && ramwe;
  assign w_stat_re = dm_sel && (ramadr == STATUS_ADDR) && ramre;
  assign w_stat_we = dm_sel && (ramadr == STATUS_ADDR) && ramwe;
  assign w_txd_re  = dm_sel && (ramadr == TXD_ADDR)    && ramre;
  assign w_txd_we  = dm_sel && (ramadr == TXD_ADDR)    && ramwe;
  assign w_rxd_re  = dm_sel && (ramadr == RXD_ADDR)    && ramre;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);

  assign xb_enable = r_ctrl[0];
  assign tx_valid  = r_ctrl[0] && !w_tx_empty;
  assign tx_data   = r_tx_mem[r_tx_rp];
  assign rx_ready  = r_ctrl[0] && !w_rx_full && clken;

  // Flush overrides every push/pop in its cycle. Full/empty are judged on
  // the pre-edge counts, so a push into a full TX FIFO is dropped even if
  // the XB pops in the same cycle.
  assign w_flush   = clken && w_ctrl_we && dbus_in[7];
  assign w_tx_pop  = tx_valid && tx_ready && clken && !w_flush;
  assign w_tx_push = w_txd_we && clken && !w_tx_full && !w_flush;
  assign w_ovf_set = w_txd_we && clken && w_tx_full;
  assign w_rx_push = rx_valid && rx_ready && !w_flush;
  assign w_rx_pop  = w_rxd_re && clken && !w_rx_empty && !w_flush;
  assign w_udf_set = w_rxd_re && clken && w_rx_empty;

  assign irq = (r_ctrl[1] && !w_rx_empty) || (r_ctrl[2] && w_tx_empty) ||
               (r_ctrl[3] && (r_tx_ovf || r_rx_udf));

  assign w_status = {1'b0, irq, r_rx_udf, r_tx_ovf,
                     w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

  always_comb begin
    w_rd = 8'h00;
    if (w_ctrl_re) w_rd = {1'b0, r_ctrl};
    if (w_stat_re) w_rd = w_status;
    if (w_rxd_re)  w_rd = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
  end

  assign dbus_out  = w_rd;
  assign io_out_en = w_ctrl_re || w_stat_re || w_txd_re || w_rxd_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl   <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else if (clken) begin
      if (w_ctrl_we) r_ctrl <= dbus_in[6:0];

      // set beats write-1-to-clear
      if (w_ovf_set)                    r_tx_ovf <= 1'b1;
      else if (w_stat_we && dbus_in[4]) r_tx_ovf <= 1'b0;
      if (w_udf_set)                    r_rx_udf <= 1'b1;
      else if (w_stat_we && dbus_in[5]) r_rx_udf <= 1'b0;

      if (w_flush) begin
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_rx_wp  <= '0;
        r_rx_rp  <= '0;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
        if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        case ({w_tx_push, w_tx_pop})
          2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
          2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
          default: ;
        endcase
        case ({w_rx_push, w_rx_pop})
          2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
          2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Storage is not reset; the counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_tx_push) r_tx_mem[r_tx_wp] <= dbus_in;
    if (!rst && w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
  end

endmodule
